// File: rtl/qarctan_share_arbiter.sv
// rtl/qarctan_share_arbiter.sv - shares one qarctan engine between two channels with in-order tagged returns
// Optional: define QARB_FIXED_PRIO_EN for fixed ch0 priority instead of round-robin.
module qarctan_share_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    output logic                                     ch0_re_rd_en,
    input  logic                                     ch0_re_empty,
    input  logic [DATA_WIDTH-1:0]                    ch0_re_dout,
    output logic                                     ch0_im_rd_en,
    input  logic                                     ch0_im_empty,
    input  logic [DATA_WIDTH-1:0]                    ch0_im_dout,
    output logic                                     ch0_out_wr_en,
    input  logic                                     ch0_out_full,
    output logic [DATA_WIDTH-1:0]                    ch0_out_din,
    output logic                                     ch1_re_rd_en,
    input  logic                                     ch1_re_empty,
    input  logic [DATA_WIDTH-1:0]                    ch1_re_dout,
    output logic                                     ch1_im_rd_en,
    input  logic                                     ch1_im_empty,
    input  logic [DATA_WIDTH-1:0]                    ch1_im_dout,
    output logic                                     ch1_out_wr_en,
    input  logic                                     ch1_out_full,
    output logic [DATA_WIDTH-1:0]                    ch1_out_din,
    output logic                                     eng_wr_en,
    input  logic                                     eng_full,
    output logic [DATA_WIDTH-1:0]                    eng_re_din,
    output logic [DATA_WIDTH-1:0]                    eng_im_din,
    output logic                                     eng_rd_en,
    input  logic                                     eng_empty,
    input  logic [DATA_WIDTH-1:0]                    eng_dout,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     err_orphan
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] TAG_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {ISS_IDLE, ISS_WRITE} iss_state_t;
    typedef enum logic {RET_IDLE, RET_WRITE} ret_state_t;

    iss_state_t          r_iss_state;
    ret_state_t          r_ret_state;
    logic                r_rr_ptr;
    logic                r_iss_tag;
    logic                r_ret_tag;
    logic [DATA_WIDTH-1:0] r_eng_re_din;
    logic [DATA_WIDTH-1:0] r_eng_im_din;
    logic [DATA_WIDTH-1:0] r_ch0_out_din;
    logic [DATA_WIDTH-1:0] r_ch1_out_din;
    logic                r_tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]       r_tag_wr_ptr;
    logic [PW-1:0]       r_tag_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_err_orphan;

    logic w_elig0, w_elig1, w_any_elig, w_winner;
    logic w_tag_full, w_tag_empty, w_head_tag;
    logic w_grant, w_push, w_eng_rd, w_pop, w_ret_full, w_deliver;

    assign w_elig0    = !ch0_re_empty && !ch0_im_empty;
    assign w_elig1    = !ch1_re_empty && !ch1_im_empty;
    assign w_any_elig = w_elig0 || w_elig1;

`ifdef QARB_FIXED_PRIO_EN
    assign w_winner = !w_elig0;
`else
    // Pointer only breaks ties; a lone eligible channel always wins.
    assign w_winner = (w_elig0 && w_elig1) ? r_rr_ptr : !w_elig0;
`endif

    assign w_tag_full  = (r_count == TAG_MAX);
    assign w_tag_empty = (r_count == '0);
    assign w_head_tag  = r_tag_mem[r_tag_rd_ptr];

    // Strobes are gated by reset so nothing touches the external FIFOs during reset.
    assign w_grant    = !reset && (r_iss_state == ISS_IDLE) && w_any_elig && !w_tag_full;
    assign w_push     = !reset && (r_iss_state == ISS_WRITE) && !eng_full;
    assign w_eng_rd   = !reset && (r_ret_state == RET_IDLE) && !eng_empty;
    assign w_pop      = w_eng_rd && !w_tag_empty;
    assign w_ret_full = r_ret_tag ? ch1_out_full : ch0_out_full;
    assign w_deliver  = !reset && (r_ret_state == RET_WRITE) && !w_ret_full;

    assign ch0_re_rd_en  = w_grant && !w_winner;
    assign ch0_im_rd_en  = w_grant && !w_winner;
    assign ch1_re_rd_en  = w_grant && w_winner;
    assign ch1_im_rd_en  = w_grant && w_winner;
    assign eng_wr_en     = w_push;
    assign eng_re_din    = r_eng_re_din;
    assign eng_im_din    = r_eng_im_din;
    assign eng_rd_en     = w_eng_rd;
    assign ch0_out_wr_en = w_deliver && !r_ret_tag;
    assign ch1_out_wr_en = w_deliver && r_ret_tag;
    assign ch0_out_din   = r_ch0_out_din;
    assign ch1_out_din   = r_ch1_out_din;
    assign outstanding   = r_count;
    assign err_orphan    = r_err_orphan;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_tag_mem[r_tag_wr_ptr] <= r_iss_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_iss_state   <= ISS_IDLE;
            r_ret_state   <= RET_IDLE;
            r_rr_ptr      <= 1'b0;
            r_iss_tag     <= 1'b0;
            r_ret_tag     <= 1'b0;
            r_eng_re_din  <= '0;
            r_eng_im_din  <= '0;
            r_ch0_out_din <= '0;
            r_ch1_out_din <= '0;
            r_tag_wr_ptr  <= '0;
            r_tag_rd_ptr  <= '0;
            r_count       <= '0;
            r_err_orphan  <= 1'b0;
        end else begin
            case (r_iss_state)
                ISS_IDLE: begin
                    if (w_grant) begin
                        r_eng_re_din <= w_winner ? ch1_re_dout : ch0_re_dout;
                        r_eng_im_din <= w_winner ? ch1_im_dout : ch0_im_dout;
                        r_iss_tag    <= w_winner;
`ifdef QARB_FIXED_PRIO_EN
                        r_rr_ptr     <= 1'b0;
`else
                        r_rr_ptr     <= !w_winner;
`endif
                        r_iss_state  <= ISS_WRITE;
                    end
                end
                ISS_WRITE: begin
                    if (w_push) begin
                        r_tag_wr_ptr <= (r_tag_wr_ptr == PTR_LAST) ? '0 : r_tag_wr_ptr + PW'(1);
                        r_iss_state  <= ISS_IDLE;
                    end
                end
                default: r_iss_state <= ISS_IDLE;
            endcase

            case (r_ret_state)
                RET_IDLE: begin
                    if (w_pop) begin
                        r_ret_tag <= w_head_tag;
                        if (w_head_tag) begin
                            r_ch1_out_din <= eng_dout;
                        end else begin
                            r_ch0_out_din <= eng_dout;
                        end
                        r_tag_rd_ptr <= (r_tag_rd_ptr == PTR_LAST) ? '0 : r_tag_rd_ptr + PW'(1);
                        r_ret_state  <= RET_WRITE;
                    end else if (w_eng_rd) begin
                        r_err_orphan <= 1'b1;
                    end
                end
                RET_WRITE: begin
                    if (w_deliver) begin
                        r_ret_state <= RET_IDLE;
                    end
                end
                default: r_ret_state <= RET_IDLE;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_qarctan_share_arbiter.sv
// tb/tb_qarctan_share_arbiter.sv - directed self-checking bench for qarctan_share_arbiter
module tb_qarctan_share_arbiter;

    localparam int DW  = 32;
    localparam int MO  = 8;
    localparam int LAT = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ch0_re_rd_en, ch0_im_rd_en, ch1_re_rd_en, ch1_im_rd_en;
    logic          ch0_re_empty, ch0_im_empty, ch1_re_empty, ch1_im_empty;
    logic [DW-1:0] ch0_re_dout, ch0_im_dout, ch1_re_dout, ch1_im_dout;
    logic          ch0_out_wr_en, ch1_out_wr_en, ch0_out_full, ch1_out_full;
    logic [DW-1:0] ch0_out_din, ch1_out_din;
    logic          eng_wr_en, eng_full, eng_rd_en, eng_empty;
    logic [DW-1:0] eng_re_din, eng_im_din, eng_dout;
    logic [3:0]    outstanding;
    logic          err_orphan;

    always #5 clock = ~clock;

    qarctan_share_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset(reset),
        .ch0_re_rd_en(ch0_re_rd_en), .ch0_re_empty(ch0_re_empty), .ch0_re_dout(ch0_re_dout),
        .ch0_im_rd_en(ch0_im_rd_en), .ch0_im_empty(ch0_im_empty), .ch0_im_dout(ch0_im_dout),
        .ch0_out_wr_en(ch0_out_wr_en), .ch0_out_full(ch0_out_full), .ch0_out_din(ch0_out_din),
        .ch1_re_rd_en(ch1_re_rd_en), .ch1_re_empty(ch1_re_empty), .ch1_re_dout(ch1_re_dout),
        .ch1_im_rd_en(ch1_im_rd_en), .ch1_im_empty(ch1_im_empty), .ch1_im_dout(ch1_im_dout),
        .ch1_out_wr_en(ch1_out_wr_en), .ch1_out_full(ch1_out_full), .ch1_out_din(ch1_out_din),
        .eng_wr_en(eng_wr_en), .eng_full(eng_full), .eng_re_din(eng_re_din), .eng_im_din(eng_im_din),
        .eng_rd_en(eng_rd_en), .eng_empty(eng_empty), .eng_dout(eng_dout),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    logic [63:0] q0[$], q1[$], eng_in_q[$];
    int          eng_t[$];
    logic [31:0] eng_out_q[$], got0[$], got1[$];
    logic [32:0] wlog[$];
    int          grants[$];

    int checks = 0, failures = 0, cyc = 0;
    bit eng_hold = 0, eng_full_force = 0, full0 = 0, full1 = 0, eng_const_en = 0;
    logic [31:0] eng_const = '0;
    logic [63:0] last_eng_in = '0;
    int erd_cnt = 0, rd_cyc = -1, wr_cyc = -1, max_out = 0, pair_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        ch0_re_empty = (q0.size() == 0);
        ch0_im_empty = (q0.size() == 0);
        ch1_re_empty = (q1.size() == 0);
        ch1_im_empty = (q1.size() == 0);
        ch0_re_dout  = (q0.size() != 0) ? q0[0][63:32] : '0;
        ch0_im_dout  = (q0.size() != 0) ? q0[0][31:0]  : '0;
        ch1_re_dout  = (q1.size() != 0) ? q1[0][63:32] : '0;
        ch1_im_dout  = (q1.size() != 0) ? q1[0][31:0]  : '0;
        eng_empty    = (eng_out_q.size() == 0);
        eng_dout     = (eng_out_q.size() != 0) ? eng_out_q[0] : '0;
        eng_full     = eng_full_force;
        ch0_out_full = full0;
        ch1_out_full = full1;
    endtask

    // Sample strobes mid-cycle, then update the FIFO/engine models after the edge.
    task automatic cycle();
        logic        r0, r1, w, er, o0, o1;
        logic [31:0] ere, eim, o0d, o1d;
        logic [63:0] e;
        @(negedge clock);
        r0 = ch0_re_rd_en; r1 = ch1_re_rd_en; w = eng_wr_en; er = eng_rd_en;
        o0 = ch0_out_wr_en; o1 = ch1_out_wr_en;
        ere = eng_re_din; eim = eng_im_din; o0d = ch0_out_din; o1d = ch1_out_din;
        if (ch0_re_rd_en !== ch0_im_rd_en || ch1_re_rd_en !== ch1_im_rd_en) pair_err++;
        if (r0) begin grants.push_back(0); rd_cyc = cyc; end
        if (r1) begin grants.push_back(1); rd_cyc = cyc; end
        if (w) begin wr_cyc = cyc; last_eng_in = {ere, eim}; end
        if (er) erd_cnt++;
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        @(posedge clock);
        #1;
        cyc++;
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        if (r1 && q1.size() != 0) void'(q1.pop_front());
        if (w) begin eng_in_q.push_back({ere, eim}); eng_t.push_back(cyc); end
        if (er && eng_out_q.size() != 0) void'(eng_out_q.pop_front());
        if (o0) begin got0.push_back(o0d); wlog.push_back({1'b0, o0d}); end
        if (o1) begin got1.push_back(o1d); wlog.push_back({1'b1, o1d}); end
        while (!eng_hold && eng_in_q.size() != 0 && eng_t[0] + LAT <= cyc) begin
            e = eng_in_q.pop_front();
            void'(eng_t.pop_front());
            eng_out_q.push_back(eng_const_en ? eng_const : e[63:32] + 32'd3 * e[31:0]);
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); eng_in_q.delete(); eng_t.delete(); eng_out_q.delete();
        got0.delete(); got1.delete(); wlog.delete(); grants.delete();
        eng_hold = 0; eng_full_force = 0; full0 = 0; full1 = 0; eng_const_en = 0;
        drive();
        cycle();
        cycle();
        reset = 1'b0;
        erd_cnt = 0; max_out = 0; rd_cyc = -1; wr_cyc = -1;
        drive();
    endtask

    initial begin
        int bad;
        logic [15:0] gp;
        drive();

        // Reset state
        do_reset();
        check("rst_ch0_rd_en", ch0_re_rd_en, 0);
        check("rst_ch1_rd_en", ch1_re_rd_en, 0);
        check("rst_eng_wr_en", eng_wr_en, 0);
        check("rst_eng_rd_en", eng_rd_en, 0);
        check("rst_out_wr_en", {ch0_out_wr_en, ch1_out_wr_en}, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_dins", {eng_re_din, eng_im_din}, 0);
        check("rst_out_dins", {ch0_out_din, ch1_out_din}, 0);

        // Single channel, constant engine result
        eng_const_en = 1; eng_const = 32'h1234;
        q0.push_back({32'd100, 32'hFFFF_FFCE});
        drive();
        repeat (30) cycle();
        check("t1_ch0_count", got0.size(), 1);
        check("t1_ch0_value", (got0.size() != 0) ? got0[0] : 32'hx, 32'h1234);
        check("t1_ch1_count", got1.size(), 0);
        check("t1_max_outstanding", max_out, 1);
        check("t1_outstanding_end", outstanding, 0);
        check("t1_issue_latency", wr_cyc - rd_cyc, 1);
        check("t1_eng_words", last_eng_in, {32'd100, 32'hFFFF_FFCE});
        check("t1_ch0_out_din", ch0_out_din, 32'h1234);

        // Both channels eligible: alternating grants, per-channel order kept
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back({32'(1000 + i), 32'(i)});
            q1.push_back({32'(2000 + i), 32'(-i)});
        end
        drive();
        for (int i = 0; i < 400 && !(got0.size() == 8 && got1.size() == 8); i++) cycle();
        check("t2_grant_count", grants.size(), 16);
        gp = '0;
        for (int i = 0; i < grants.size() && i < 16; i++) gp[i] = grants[i][0];
        check("t2_grant_pattern", gp, 16'hAAAA);
        bad = 0;
        if (got0.size() != 8) bad = 99;
        else for (int i = 0; i < 8; i++) if (got0[i] !== 32'(1000 + 4 * i)) bad++;
        check("t2_ch0_results", bad, 0);
        bad = 0;
        if (got1.size() != 8) bad = 99;
        else for (int i = 0; i < 8; i++) if (got1[i] !== 32'(2000 - 2 * i)) bad++;
        check("t2_ch1_results", bad, 0);

        // Engine stalled: tag FIFO fills to MAX_OUTSTANDING
        do_reset();
        eng_hold = 1;
        for (int i = 0; i < 12; i++) begin
            q0.push_back({32'(5000 + i), 32'd1});
            q1.push_back({32'(6000 + i), 32'd2});
        end
        drive();
        repeat (60) cycle();
        check("t3_issues", grants.size(), 8);
        check("t3_outstanding_full", outstanding, 8);
        check("t3_eng_in_count", eng_in_q.size(), 8);
        check("t3_rd_en_idle", {ch0_re_rd_en, ch1_re_rd_en}, 0);
        eng_hold = 0;
        for (int i = 0; i < 800 && got0.size() + got1.size() < 24; i++) cycle();
        check("t3_drained", got0.size() + got1.size(), 24);
        check("t3_max_outstanding", max_out, 8);
        check("t3_outstanding_end", outstanding, 0);

        // Head-of-line blocking on ch1 output full
        do_reset();
        full1 = 1;
        q1.push_back({32'd3000, 32'd1});
        drive();
        repeat (3) cycle();
        q0.push_back({32'd10, 32'd1});
        q0.push_back({32'd20, 32'd2});
        drive();
        repeat (40) cycle();
        check("t4_no_writes", wlog.size(), 0);
        check("t4_outstanding_blocked", outstanding, 2);
        check("t4_eng_queued", eng_out_q.size(), 2);
        full1 = 0;
        drive();
        repeat (20) cycle();
        check("t4_write_count", wlog.size(), 3);
        check("t4_first_ch1", (wlog.size() > 0) ? wlog[0] : 33'hx, {1'b1, 32'd3003});
        check("t4_second_ch0", (wlog.size() > 1) ? wlog[1] : 33'hx, {1'b0, 32'd13});
        check("t4_third_ch0", (wlog.size() > 2) ? wlog[2] : 33'hx, {1'b0, 32'd26});

        // Orphan result with no tag pending
        do_reset();
        eng_out_q.push_back(32'hDEAD);
        drive();
        repeat (5) cycle();
        check("t5_eng_rd_pulses", erd_cnt, 1);
        check("t5_err_orphan", err_orphan, 1);
        check("t5_no_writes", wlog.size(), 0);
        repeat (10) cycle();
        check("t5_err_sticky", err_orphan, 1);

        // Reset while stalled in ISS_WRITE
        do_reset();
        check("t6_err_cleared", err_orphan, 0);
        eng_full_force = 1;
        q0.push_back({32'd7, 32'd7});
        drive();
        repeat (4) cycle();
        check("t6_granted", grants.size(), 1);
        check("t6_stalled_wr", eng_wr_en, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        eng_full_force = 0;
        drive();
        check("t6_wr_after_reset", eng_wr_en, 0);
        check("t6_outstanding", outstanding, 0);
        grants.delete();
        q0.push_back({32'd1, 32'd1});
        q1.push_back({32'd2, 32'd2});
        drive();
        repeat (6) cycle();
        check("t6_first_grant_ch0", (grants.size() > 0) ? grants[0] : -1, 0);

        check("rd_en_pairs", pair_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
